// File: rtl/axis_packetizer_pkg.sv
// ---------------------------------------------------------------------------
// axis_packetizer_pkg
// Shared types for the AXI-Stream packetizer: the hold-stage FSM states, the
// beat record carried through the hold and output stages, the datapath widths
// that record is built from, and a small width helper for the counters.
// No ports (package).
// ---------------------------------------------------------------------------
package axis_packetizer_pkg;

  // The hold-beat record is sized from these; the top-level width parameters
  // default to the same values and must agree with them.
  localparam int PKT_TDATA_W = 32;
  localparam int PKT_TID_W   = 2;
  localparam int PKT_TDEST_W = 4;

  // EMPTY: nothing held. HOLD: beat held, end-of-packet still undecided.
  // FLUSH: beat held and known to be last (or known not to need deciding).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } pkt_state_e;

  typedef struct packed {
    logic [PKT_TDATA_W-1:0] data;
    logic                   last;
    logic [PKT_TDEST_W-1:0] dest;
    logic [PKT_TID_W-1:0]   id;
  } hold_beat_t;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int bits_for(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/axis_packetizer_outreg.sv
// ---------------------------------------------------------------------------
// axis_packetizer_outreg
// Registered AXI-Stream output slice. Accepts a beat whenever the slice is
// free (empty or being drained this cycle) and holds its contents stable while
// the downstream side stalls.
// Ports:
//   i_clk, i_rst  clock and asynchronous active-high reset
//   i_load        a new beat is offered this cycle (only taken when o_free)
//   i_beat        the beat offered
//   i_ready       downstream ready
//   o_free        slice can take a beat this cycle (!valid || ready)
//   o_valid, o_data, o_last, o_dest, o_id   registered AXIS outputs
// ---------------------------------------------------------------------------
module axis_packetizer_outreg
  import axis_packetizer_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load,
  input  hold_beat_t             i_beat,
  input  logic                   i_ready,
  output logic                   o_free,
  output logic                   o_valid,
  output logic [PKT_TDATA_W-1:0] o_data,
  output logic                   o_last,
  output logic [PKT_TDEST_W-1:0] o_dest,
  output logic [PKT_TID_W-1:0]   o_id
);

  hold_beat_t r_beat;
  logic       r_valid;

  assign o_free = !r_valid || i_ready;

  // Output register: only changes when free, so a stalled beat stays put and
  // valid drops after a handshake when nothing new arrives.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else if (o_free) begin
      r_valid <= i_load;
      if (i_load) begin
        r_beat <= i_beat;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_beat.data;
  assign o_last  = r_beat.last;
  assign o_dest  = r_beat.dest;
  assign o_id    = r_beat.id;

endmodule

// File: rtl/axis_packetizer.sv
// ---------------------------------------------------------------------------
// axis_packetizer
// Turns a loosely framed user stream into bounded AXI-Stream packets. One beat
// is held back so that tlast can still be set on it if the input goes idle.
// A packet closes on user tlast, on reaching MAX_PKT_BEATS, or after
// IDLE_TIMEOUT idle cycles with a beat held (0 disables the timeout).
// tdest/tid are sampled from cfg_* on the first beat of each packet.
// Ports:
//   clk_usr, rst_usr        clock, asynchronous active-high reset
//   s_tvalid/s_tready/s_tdata/s_tlast   upstream stream
//   cfg_tdest, cfg_tid      per-packet routing fields
//   m_tvalid/m_tready/m_tdata/m_tlast/m_tdest/m_tid   registered downstream
//   pkt_count               packets emitted (tlast handshakes), wraps
//   flush_count             packets closed by idle timeout, wraps
// ---------------------------------------------------------------------------
module axis_packetizer
  import axis_packetizer_pkg::*;
#(
  parameter int TDATA_WIDTH   = PKT_TDATA_W,
  parameter int TID_WIDTH     = PKT_TID_W,
  parameter int TDEST_WIDTH   = PKT_TDEST_W,
  parameter int MAX_PKT_BEATS = 16,
  parameter int IDLE_TIMEOUT  = 64,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                   clk_usr,
  input  logic                   rst_usr,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [TDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  input  logic [TDEST_WIDTH-1:0] cfg_tdest,
  input  logic [TID_WIDTH-1:0]   cfg_tid,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [TDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  output logic [TDEST_WIDTH-1:0] m_tdest,
  output logic [TID_WIDTH-1:0]   m_tid,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]   flush_count
);

  localparam int CW = bits_for(MAX_PKT_BEATS);
  localparam int IW = bits_for(IDLE_TIMEOUT);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_PKT_BEATS);
  localparam logic [IW-1:0] IDLE_LAST = IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  pkt_state_e    r_state, w_state_next;
  hold_beat_t    r_hold, w_hold_next;
  logic [CW-1:0] r_beat_cnt, w_beat_cnt_next, w_new_cnt;
  logic [IW-1:0] r_idle_cnt, w_idle_cnt_next;

  logic w_o_free;
  logic w_accept;
  logic w_h_move;
  logic w_timeout;
  logic w_first;
  logic w_load_last;

  // s_tready combinationally follows m_tready through o_free so the hold
  // stage can swap beats every cycle without bubbles.
  assign s_tready = !rst_usr && ((r_state == EMPTY) || w_o_free);
  assign w_accept = s_tvalid && s_tready;

  // Next-state logic for the hold stage. A beat arriving while not in HOLD
  // starts a packet: in FLUSH the held beat leaves as last in the same cycle,
  // and EMPTY is only ever reached at a packet boundary.
  always_comb begin
    w_state_next    = r_state;
    w_hold_next     = r_hold;
    w_beat_cnt_next = r_beat_cnt;
    w_idle_cnt_next = '0;
    w_h_move        = 1'b0;
    w_timeout       = 1'b0;
    w_first         = (r_state != HOLD);
    w_new_cnt       = w_first ? CW'(1) : (r_beat_cnt + 1'b1);
    w_load_last     = s_tlast || (w_new_cnt == MAX_CNT);

    case (r_state)
      EMPTY: begin
        w_h_move = 1'b0;
      end
      HOLD: begin
        if (w_accept) begin
          w_h_move = 1'b1;
        end else if ((IDLE_TIMEOUT > 0) && (r_idle_cnt == IDLE_LAST)) begin
          w_timeout        = 1'b1;
          w_hold_next.last = 1'b1;
          w_state_next     = FLUSH;
        end else if (IDLE_TIMEOUT > 0) begin
          w_idle_cnt_next = r_idle_cnt + 1'b1;
        end
      end
      FLUSH: begin
        if (w_accept) begin
          w_h_move = 1'b1;
        end else if (w_o_free) begin
          w_h_move        = 1'b1;
          w_state_next    = EMPTY;
          w_beat_cnt_next = '0;
        end
      end
      default: begin
        w_state_next    = EMPTY;
        w_beat_cnt_next = '0;
      end
    endcase

    if (w_accept) begin
      w_hold_next.data = s_tdata;
      w_hold_next.last = w_load_last;
      w_hold_next.dest = w_first ? cfg_tdest : r_hold.dest;
      w_hold_next.id   = w_first ? cfg_tid : r_hold.id;
      w_beat_cnt_next  = w_new_cnt;
      w_state_next     = w_load_last ? FLUSH : HOLD;
    end
  end

  // Hold-stage state, held beat and packet/idle counters.
  always_ff @(posedge clk_usr or posedge rst_usr) begin
    if (rst_usr) begin
      r_state    <= EMPTY;
      r_hold     <= '0;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_hold     <= w_hold_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_idle_cnt <= w_idle_cnt_next;
    end
  end

  // Statistics: emitted packets are counted at the downstream handshake,
  // timeout closures when the held beat is forced last.
  always_ff @(posedge clk_usr or posedge rst_usr) begin
    if (rst_usr) begin
      pkt_count   <= '0;
      flush_count <= '0;
    end else begin
      if (m_tvalid && m_tready && m_tlast) begin
        pkt_count <= pkt_count + 1'b1;
      end
      if (w_timeout) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

  axis_packetizer_outreg u_outreg (
    .i_clk   (clk_usr),
    .i_rst   (rst_usr),
    .i_load  (w_h_move),
    .i_beat  (r_hold),
    .i_ready (m_tready),
    .o_free  (w_o_free),
    .o_valid (m_tvalid),
    .o_data  (m_tdata),
    .o_last  (m_tlast),
    .o_dest  (m_tdest),
    .o_id    (m_tid)
  );

endmodule

// File: tb/tb_axis_packetizer.sv
// ---------------------------------------------------------------------------
// tb_axis_packetizer
// Directed bench for axis_packetizer: a MAX_PKT_BEATS=16 instance for most
// scenarios and a MAX_PKT_BEATS=1 instance for the single-beat packet case.
// Output beats are collected into queues at each handshake and compared to
// hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_axis_packetizer;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  dest;
    logic [1:0]  id;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        sTvalid = 1'b0, sTready, sTlast = 1'b0;
  logic [31:0] sTdata = '0;
  logic        mTvalid, mTready = 1'b1, mTlast;
  logic [31:0] mTdata;
  logic [3:0]  mTdest;
  logic [1:0]  mTid;
  logic [31:0] pktCount, flushCount;

  logic        s1Tvalid = 1'b0, s1Tready, s1Tlast = 1'b0;
  logic [31:0] s1Tdata = '0;
  logic        m1Tvalid, m1Tlast;
  logic [31:0] m1Tdata;
  logic [3:0]  m1Tdest;
  logic [1:0]  m1Tid;
  logic [31:0] pkt1Count, flush1Count;

  logic [3:0]  cfgTdest = 4'h0;
  logic [1:0]  cfgTid = 2'd0;

  int testsRun = 0;
  int failCount = 0;

  beat_t outQ[$];
  beat_t out1Q[$];

  logic        toggleReady = 1'b0;
  logic        stallCheck = 1'b0;
  logic        prevStall = 1'b0;
  logic [31:0] heldData = '0;
  logic        heldLast = 1'b0;

  always #5 clk = ~clk;

  axis_packetizer #(.MAX_PKT_BEATS(16), .IDLE_TIMEOUT(64)) dut (
    .clk_usr(clk), .rst_usr(rst),
    .s_tvalid(sTvalid), .s_tready(sTready), .s_tdata(sTdata), .s_tlast(sTlast),
    .cfg_tdest(cfgTdest), .cfg_tid(cfgTid),
    .m_tvalid(mTvalid), .m_tready(mTready), .m_tdata(mTdata), .m_tlast(mTlast),
    .m_tdest(mTdest), .m_tid(mTid),
    .pkt_count(pktCount), .flush_count(flushCount)
  );

  axis_packetizer #(.MAX_PKT_BEATS(1), .IDLE_TIMEOUT(64)) dut1 (
    .clk_usr(clk), .rst_usr(rst),
    .s_tvalid(s1Tvalid), .s_tready(s1Tready), .s_tdata(s1Tdata), .s_tlast(s1Tlast),
    .cfg_tdest(cfgTdest), .cfg_tid(cfgTid),
    .m_tvalid(m1Tvalid), .m_tready(1'b1), .m_tdata(m1Tdata), .m_tlast(m1Tlast),
    .m_tdest(m1Tdest), .m_tid(m1Tid),
    .pkt_count(pkt1Count), .flush_count(flush1Count)
  );

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Offer one beat to the chosen instance and wait (bounded) until it is taken.
  task automatic applyStimulus(input bit toSecond, input logic [31:0] data, input logic last);
    int   guard;
    logic rdy;
    guard = 0;
    if (toSecond) begin
      s1Tvalid = 1'b1; s1Tdata = data; s1Tlast = last;
    end else begin
      sTvalid = 1'b1; sTdata = data; sTlast = last;
    end
    @(negedge clk);
    rdy = toSecond ? s1Tready : sTready;
    while (!rdy && guard < 200) begin
      @(negedge clk);
      guard++;
      rdy = toSecond ? s1Tready : sTready;
    end
    if (!rdy) checkOutput("acceptTimeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if (toSecond) begin
      s1Tvalid = 1'b0; s1Tlast = 1'b0;
    end else begin
      sTvalid = 1'b0; sTlast = 1'b0;
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    sTvalid = 1'b0; sTlast = 1'b0;
    s1Tvalid = 1'b0; s1Tlast = 1'b0;
    mTready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    outQ.delete();
    out1Q.delete();
  endtask

  // Capture handshakes; inputs only change just after posedge, so the
  // negedge view matches what the next rising edge will see.
  always @(negedge clk) begin
    if (!rst && mTvalid && mTready) outQ.push_back('{mTdata, mTlast, mTdest, mTid});
    if (!rst && m1Tvalid) out1Q.push_back('{m1Tdata, m1Tlast, m1Tdest, m1Tid});
  end

  // Backpressure pattern for the stall scenario.
  always @(posedge clk) begin
    if (toggleReady) begin
      #1 mTready = ~mTready;
    end
  end

  // Outputs must not move while a stalled beat is waiting.
  always @(negedge clk) begin
    if (stallCheck && prevStall) begin
      checkOutput("stallValid", {63'd0, mTvalid}, 64'd1);
      checkOutput("stallData", {32'd0, mTdata}, {32'd0, heldData});
      checkOutput("stallLast", {63'd0, mTlast}, {63'd0, heldLast});
    end
    prevStall = stallCheck && mTvalid && !mTready;
    heldData  = mTdata;
    heldLast  = mTlast;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // ---- Reset state ----
    rst = 1'b1;
    #12;
    checkOutput("rstTready", {63'd0, sTready}, 64'd0);
    checkOutput("rstTvalid", {63'd0, mTvalid}, 64'd0);
    checkOutput("rstTdata", {32'd0, mTdata}, 64'd0);
    checkOutput("rstPkt", {32'd0, pktCount}, 64'd0);
    checkOutput("rstFlush", {32'd0, flushCount}, 64'd0);

    // ---- 1: 40 unframed beats -> 16, 16, then 8 closed by timeout ----
    resetDut();
    cfgTdest = 4'h5; cfgTid = 2'd1;
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 32'd100 + 32'(i), 1'b0);
    waitCycles(60);
    checkOutput("t1_beforeFlush", 64'(outQ.size()), 64'd39);
    checkOutput("t1_flushEarly", {32'd0, flushCount}, 64'd0);
    waitCycles(10);
    checkOutput("t1_count", 64'(outQ.size()), 64'd40);
    for (int i = 0; i < outQ.size(); i++) begin
      checkOutput($sformatf("t1_data%0d", i), {32'd0, outQ[i].data}, 64'd100 + 64'(i));
      checkOutput($sformatf("t1_last%0d", i), {63'd0, outQ[i].last},
                  (i == 15 || i == 31 || i == 39) ? 64'd1 : 64'd0);
    end
    if (outQ.size() == 40) begin
      checkOutput("t1_dest", {60'd0, outQ[39].dest}, 64'h5);
      checkOutput("t1_id", {62'd0, outQ[16].id}, 64'd1);
    end
    checkOutput("t1_flush", {32'd0, flushCount}, 64'd1);
    checkOutput("t1_pkt", {32'd0, pktCount}, 64'd3);

    // ---- 2: user tlast on beat 5, cfg change mid-packet ignored ----
    resetDut();
    cfgTdest = 4'h3;
    applyStimulus(1'b0, 32'd200, 1'b0);
    cfgTdest = 4'h9;
    for (int i = 1; i < 5; i++) applyStimulus(1'b0, 32'd200 + 32'(i), i == 4);
    waitCycles(4);
    checkOutput("t2_count", 64'(outQ.size()), 64'd5);
    for (int i = 0; i < outQ.size(); i++) begin
      checkOutput($sformatf("t2_dest%0d", i), {60'd0, outQ[i].dest}, 64'h3);
      checkOutput($sformatf("t2_last%0d", i), {63'd0, outQ[i].last}, (i == 4) ? 64'd1 : 64'd0);
    end
    checkOutput("t2_flush", {32'd0, flushCount}, 64'd0);
    checkOutput("t2_pkt", {32'd0, pktCount}, 64'd1);

    // ---- 3: continuous input under 1010 backpressure ----
    resetDut();
    mTready = 1'b0;
    toggleReady = 1'b1;
    stallCheck = 1'b1;
    for (int i = 0; i < 32; i++) applyStimulus(1'b0, 32'd300 + 32'(i), 1'b0);
    waitCycles(12);
    stallCheck = 1'b0;
    toggleReady = 1'b0;
    #2;
    mTready = 1'b1;
    waitCycles(4);
    checkOutput("t3_count", 64'(outQ.size()), 64'd32);
    for (int i = 0; i < outQ.size(); i++) begin
      checkOutput($sformatf("t3_data%0d", i), {32'd0, outQ[i].data}, 64'd300 + 64'(i));
      checkOutput($sformatf("t3_last%0d", i), {63'd0, outQ[i].last},
                  (i == 15 || i == 31) ? 64'd1 : 64'd0);
    end
    checkOutput("t3_pkt", {32'd0, pktCount}, 64'd2);

    // ---- 4: 63 idle cycles then a beat: accept beats the timeout ----
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd400 + 32'(i), 1'b0);
    waitCycles(63);
    checkOutput("t4_heldCount", 64'(outQ.size()), 64'd2);
    checkOutput("t4_noFlushYet", {32'd0, flushCount}, 64'd0);
    applyStimulus(1'b0, 32'd403, 1'b0);
    applyStimulus(1'b0, 32'd404, 1'b1);
    waitCycles(4);
    checkOutput("t4_count", 64'(outQ.size()), 64'd5);
    for (int i = 0; i < outQ.size(); i++) begin
      checkOutput($sformatf("t4_data%0d", i), {32'd0, outQ[i].data}, 64'd400 + 64'(i));
      checkOutput($sformatf("t4_last%0d", i), {63'd0, outQ[i].last}, (i == 4) ? 64'd1 : 64'd0);
    end
    checkOutput("t4_flush", {32'd0, flushCount}, 64'd0);
    checkOutput("t4_pkt", {32'd0, pktCount}, 64'd1);

    // ---- 5: MAX_PKT_BEATS=1 instance, every beat is a packet ----
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'd500 + 32'(i), 1'b0);
    waitCycles(4);
    checkOutput("t5_count", 64'(out1Q.size()), 64'd3);
    for (int i = 0; i < out1Q.size(); i++) begin
      checkOutput($sformatf("t5_data%0d", i), {32'd0, out1Q[i].data}, 64'd500 + 64'(i));
      checkOutput($sformatf("t5_last%0d", i), {63'd0, out1Q[i].last}, 64'd1);
    end
    checkOutput("t5_pkt", {32'd0, pkt1Count}, 64'd3);

    // ---- 6: reset mid-packet drops everything, next packet starts fresh ----
    resetDut();
    mTready = 1'b0;
    cfgTdest = 4'h2;
    applyStimulus(1'b0, 32'd600, 1'b0);
    applyStimulus(1'b0, 32'd601, 1'b0);
    checkOutput("t6_preValid", {63'd0, mTvalid}, 64'd1);
    sTvalid = 1'b1; sTdata = 32'd602;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_rstValid", {63'd0, mTvalid}, 64'd0);
    checkOutput("t6_rstReady", {63'd0, sTready}, 64'd0);
    checkOutput("t6_rstData", {32'd0, mTdata}, 64'd0);
    sTvalid = 1'b0;
    waitCycles(2);
    rst = 1'b0;
    checkOutput("t6_noOldBeats", 64'(outQ.size()), 64'd0);
    mTready = 1'b1;
    cfgTdest = 4'hA;
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 32'd610 + 32'(i), 1'b0);
    waitCycles(4);
    checkOutput("t6_count", 64'(outQ.size()), 64'd16);
    for (int i = 0; i < outQ.size(); i++) begin
      checkOutput($sformatf("t6_data%0d", i), {32'd0, outQ[i].data}, 64'd610 + 64'(i));
      checkOutput($sformatf("t6_last%0d", i), {63'd0, outQ[i].last}, (i == 15) ? 64'd1 : 64'd0);
      checkOutput($sformatf("t6_dest%0d", i), {60'd0, outQ[i].dest}, 64'hA);
    end
    checkOutput("t6_pkt", {32'd0, pktCount}, 64'd1);
    checkOutput("t6_flush", {32'd0, flushCount}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/axis_packetizer.md
Name: axis_packetizer

Overview:
- Upstream neighbour of the AXI-Stream router input port, in the clk_usr domain. Converts an unframed or loosely framed user stream into bounded packets.
- Inserts tlast at MAX_PKT_BEATS beats, on user tlast, or after an idle timeout.
- Attaches tdest and tid, latched per packet.
- Holds back one beat so that tlast can be asserted retroactively on an idle flush.

Parameters:
- TDATA_WIDTH, 32, data width; matches the router input.
- TID_WIDTH, 2, tid width.
- TDEST_WIDTH, 4, tdest width.
- MAX_PKT_BEATS, 16, maximum beats per packet; must be >= 1.
- IDLE_TIMEOUT, 64, idle cycles with a beat held before a forced tlast; 0 disables the timeout.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk_usr  in  1  clock; all logic on the rising edge.
- rst_usr  in  1  reset, asynchronous, active-high.
- s_tvalid  in  1  upstream beat valid.
- s_tready  out  1  upstream ready.
- s_tdata  in  TDATA_WIDTH  upstream data.
- s_tlast  in  1  upstream end-of-packet hint (optional framing).
- cfg_tdest  in  TDEST_WIDTH  destination; sampled on the first beat of each packet.
- cfg_tid  in  TID_WIDTH  id; sampled on the first beat of each packet.
- m_tvalid  out  1  router-side valid (registered).
- m_tready  in  1  router-side ready.
- m_tdata  out  TDATA_WIDTH  data (registered).
- m_tlast  out  1  packet end (registered).
- m_tdest  out  TDEST_WIDTH  packet destination (registered).
- m_tid  out  TID_WIDTH  packet id (registered).
- pkt_count  out  CNT_WIDTH  packets emitted (m_tlast handshakes); wraps modulo 2^CNT_WIDTH.
- flush_count  out  CNT_WIDTH  packets closed by timeout; wraps.

Behaviour:

Datapath stages:
- H (hold): one beat, carrying data, last flag, tdest and tid.
- O (output register): drives m_*.
- o_free = !m_tvalid || m_tready.

FSM states:
- EMPTY: H empty.
- HOLD: H valid, its last flag unresolved.
- FLUSH: H valid, last flag resolved.

Ready and acceptance:
- s_tready = (state==EMPTY) || o_free. This is a combinational path from m_tready, which is deliberate.
- s_tready = 0 while rst_usr is high.
- Accept = s_tvalid && s_tready.
- On accept with H valid: H moves to O with m_tlast = H.last (0 in HOLD). The new beat loads H in the same cycle, so there are no bubbles.

Beat counting and tlast:
- beat_cnt, width clog2(MAX_PKT_BEATS+1), counts the beats of the current packet including the beat in H.
- When a beat loads H, beat_cnt becomes beat_cnt+1, or 1 if the previous beat moved to O with last=1.
- tdest/tid are sampled from cfg_* only when the loaded beat is the first beat of a packet. Later beats reuse the latched values, so cfg_* changes mid-packet have no effect.
- Loaded beat with s_tlast=1 or new beat_cnt==MAX_PKT_BEATS: H.last=1, next state FLUSH.
- Otherwise the next state is HOLD.
- MAX_PKT_BEATS==1: every beat is last.

Idle timeout:
- idle_cnt clears on any accept or on leaving HOLD, and increments in HOLD when there is no accept.
- IDLE_TIMEOUT>0 and idle_cnt reaches IDLE_TIMEOUT-1 with no accept: set H.last=1, go to FLUSH, increment flush_count.
- Accept in the same cycle as timeout: the accept wins and no flush happens.

Other transitions:
- FLUSH with o_free and no accept: H moves to O, state becomes EMPTY.
- HOLD with no accept and no timeout: H stays; a beat with last unresolved is never emitted.

Output register:
- O loads when o_free and H is moving.
- m_* are held stable while m_tvalid && !m_tready (AXIS rule).
- m_tvalid deasserts after a handshake if nothing new loads.
- pkt_count increments on m_tvalid && m_tready && m_tlast.

Latency:
- A beat is emitted to O one cycle after it is resolved.
- With continuous input, the first beat appears on m_* 2 cycles after accept, then 1 beat/cycle.

Reset:
- Async assert; all state clears immediately.
- m_tvalid=0, m_tdata/m_tlast/m_tdest/m_tid=0, state=EMPTY, beat_cnt=0, idle_cnt=0, pkt_count=0, flush_count=0.
- Reset mid-packet drops the held beat and the O beat; no partial tlast is generated.
- Release is synchronous to clk_usr (the caller supplies a synchronised deassert).

Decomposition:
- Package axis_packetizer_pkg: state enum (EMPTY/HOLD/FLUSH) and a hold-beat struct {data, last, dest, id} parameterised via localparam widths.
- One sub-module, axis_packetizer_outreg: registered AXIS output slice with stall hold.
- FSM, counters and H stay in the top module.

Test Plan:
1. Reset, then 40 back-to-back beats with s_tlast=0, m_tready=1, MAX=16 -> packets of 16, 16, then 8 held. After 64 idle cycles the 8th beat emits with m_tlast=1; flush_count=1, pkt_count=3.
2. 5 beats with s_tlast on beat 5, cfg_tdest=4'h3, cfg_tdest changed to 4'h9 after beat 1 -> one 5-beat packet, m_tdest=3 on all beats, m_tlast only on beat 5, flush_count=0.
3. Continuous input with m_tready toggling 1010... -> m_* stable during stalls, no lost or duplicated beats (scoreboard), tlast every 16th beat.
4. Input gap of exactly 63 idle cycles mid-packet, then a beat accepted on cycle 64 -> no flush; the packet continues, and accept beats timeout.
5. MAX_PKT_BEATS=1 build, 3 beats -> 3 packets, each m_tlast=1, pkt_count=3.
6. Assert rst_usr mid-packet with 3 beats in flight -> m_tvalid=0 at once; after release, the next beat starts a new packet with beat_cnt=1 and freshly sampled cfg_tdest.
